// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// instruction fields, ALU operations and datapath mux selects.
package ctrl_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_CTL_W = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'b0111;

    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_REG = 1'b1;

    localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control driven by the FSM, bundled so one default clears all.
    typedef struct packed {
        logic                 alu_src_a;
        logic [SEL_W-1:0]     alu_src_b;
        logic [ALU_CTL_W-1:0] alu_control;
        logic                 pc_write;
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 ir_write;
        logic                 mem_to_reg;
        logic                 reg_dst;
        logic                 reg_write;
        logic [SEL_W-1:0]     pc_source;
        logic                 illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation decode; valid flags supported functs.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_CTL_W-1:0] alu_control,
    output logic                 valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/writeback,
// flags unsupported instructions and counts retired instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic [ALU_CTL_W-1:0] alu_control,
    output logic                 pc_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic [SEL_W-1:0]     pc_source,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    ctrl_t                ctl;
    logic                 retire;
    logic                 branch_taken;
    logic [ALU_CTL_W-1:0] dec_alu;
    logic                 dec_valid;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (dec_alu),
        .valid       (dec_valid)
    );

    assign branch_taken = ((opcode == OP_BEQ) &  zero) |
                          ((opcode == OP_BNE) & ~zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Controls decode from the current state (and handshake/flags) in the same cycle.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ctl.mem_read    = 1'b1;
                ctl.alu_src_a   = SRCA_PC;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.pc_source   = PCSRC_ALU;
                ctl.pc_write    = mem_ready;
                ctl.ir_write    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_a   = SRCA_PC;
                ctl.alu_src_b   = SRCB_IMM_SH2;
                ctl.alu_control = ALU_ADD;
                case (opcode)
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EX;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a   = SRCA_REG;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.alu_control = ALU_ADD;
                state_d         = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ctl.alu_src_a = SRCA_REG;
                ctl.alu_src_b = SRCB_REG;
                if (dec_valid) begin
                    ctl.alu_control = dec_alu;
                    state_d         = S_RWB;
                end else begin
                    ctl.alu_control = ALU_ADD;
                    ctl.illegal     = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_RWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = SRCA_REG;
                ctl.alu_src_b   = SRCB_REG;
                ctl.alu_control = ALU_SUB;
                ctl.pc_source   = PCSRC_ALUOUT;
                ctl.pc_write    = branch_taken;
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDI_EX: begin
                ctl.alu_src_a   = SRCA_REG;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.alu_control = ALU_ADD;
                state_d         = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        retired_d = retired_q + CNT_WIDTH'(retire);
    end

    assign alu_src_a   = ctl.alu_src_a;
    assign alu_src_b   = ctl.alu_src_b;
    assign alu_control = ctl.alu_control;
    assign pc_write    = ctl.pc_write;
    assign iord        = ctl.iord;
    assign mem_read    = ctl.mem_read;
    assign mem_write   = ctl.mem_write;
    assign ir_write    = ctl.ir_write;
    assign mem_to_reg  = ctl.mem_to_reg;
    assign reg_dst     = ctl.reg_dst;
    assign reg_write   = ctl.reg_write;
    assign pc_source   = ctl.pc_source;
    assign illegal     = ctl.illegal;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction table, reset corner cases and
// random instruction streams against a per-instruction cycle-list model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         sf;
        int         sm;
        int         cyc;
        int         ret;
    } vec_t;

    logic        clk, rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;

    logic        alu_src_a, pc_write, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, illegal;
    logic [1:0]  alu_src_b, pc_source;
    logic [3:0]  alu_control;
    logic [31:0] retired;

    logic        w4_alu_src_a, w4_pc_write, w4_iord, w4_mem_read, w4_mem_write, w4_ir_write;
    logic        w4_mem_to_reg, w4_reg_dst, w4_reg_write, w4_illegal;
    logic [1:0]  w4_alu_src_b, w4_pc_source;
    logic [3:0]  w4_alu_control;
    logic [3:0]  w4_retired;

    ctl_t got, got4;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] ret_exp;

    ctl_t e_q[$];
    logic m_q[$];
    bit   r_q[$];
    int   exp_ret;

    vec_t       tbl[18];
    logic [5:0] legal_ops[7];
    logic [5:0] legal_fns[5];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .pc_source(pc_source), .illegal(illegal), .retired(retired)
    );

    multicycle_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_src_a(w4_alu_src_a), .alu_src_b(w4_alu_src_b),
        .alu_control(w4_alu_control), .pc_write(w4_pc_write), .iord(w4_iord),
        .mem_read(w4_mem_read), .mem_write(w4_mem_write), .ir_write(w4_ir_write),
        .mem_to_reg(w4_mem_to_reg), .reg_dst(w4_reg_dst), .reg_write(w4_reg_write),
        .pc_source(w4_pc_source), .illegal(w4_illegal), .retired(w4_retired)
    );

    assign got  = {alu_src_a, alu_src_b, alu_control, pc_write, iord, mem_read, mem_write,
                   ir_write, mem_to_reg, reg_dst, reg_write, pc_source, illegal};
    assign got4 = {w4_alu_src_a, w4_alu_src_b, w4_alu_control, w4_pc_write, w4_iord,
                   w4_mem_read, w4_mem_write, w4_ir_write, w4_mem_to_reg, w4_reg_dst,
                   w4_reg_write, w4_pc_source, w4_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic check_ctl(input string name, input ctl_t act, input ctl_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Control signatures of each instruction phase; anything unnamed is 0.
    function automatic ctl_t c_fetch(input logic mr);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_control = 4'b0010;
        c.pc_write = mr;   c.ir_write  = mr;
        return c;
    endfunction

    function automatic ctl_t c_decode(input logic ill);
        ctl_t c = '0;
        c.alu_src_b = 2'b11; c.alu_control = 4'b0010; c.illegal = ill;
        return c;
    endfunction

    function automatic ctl_t c_addr();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic wr);
        ctl_t c = '0;
        c.iord = 1'b1; c.mem_read = ~wr; c.mem_write = wr;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic mtr, input logic rd);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = mtr; c.reg_dst = rd;
        return c;
    endfunction

    function automatic ctl_t c_exec(input logic [3:0] alu, input logic ill);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_control = alu; c.illegal = ill;
        return c;
    endfunction

    function automatic ctl_t c_branch(input logic taken);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_control = 4'b0110; c.pc_source = 2'b01; c.pc_write = taken;
        return c;
    endfunction

    function automatic ctl_t c_jump();
        ctl_t c = '0;
        c.pc_write = 1'b1; c.pc_source = 2'b10;
        return c;
    endfunction

    function automatic void push(input ctl_t c, input logic mr, input bit r);
        e_q.push_back(c); m_q.push_back(mr); r_q.push_back(r);
        if (r) exp_ret++;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle list of one instruction, with the mem_ready to drive each cycle.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                  input int sf, input int sm);
        logic [3:0] alu;
        logic       ok;
        e_q.delete(); m_q.delete(); r_q.delete(); exp_ret = 0;
        for (int k = 0; k < sf; k++) push(c_fetch(1'b0), 1'b0, 1'b0);
        push(c_fetch(1'b1), 1'b1, 1'b0);
        ok = 1'b1;
        case (fn)
            6'b100000: alu = 4'b0010;
            6'b100010: alu = 4'b0110;
            6'b100100: alu = 4'b0000;
            6'b100101: alu = 4'b0001;
            6'b101010: alu = 4'b0111;
            default: begin alu = 4'b0010; ok = 1'b0; end
        endcase
        case (op)
            6'b000000: begin
                push(c_decode(1'b0), rnd(), 1'b0);
                push(c_exec(alu, ~ok), rnd(), 1'b0);
                if (ok) push(c_wb(1'b0, 1'b1), rnd(), 1'b1);
            end
            6'b100011, 6'b101011: begin
                push(c_decode(1'b0), rnd(), 1'b0);
                push(c_addr(), rnd(), 1'b0);
                for (int k = 0; k < sm; k++) push(c_mem(op[3]), 1'b0, 1'b0);
                push(c_mem(op[3]), 1'b1, op[3]);
                if (!op[3]) push(c_wb(1'b1, 1'b0), rnd(), 1'b1);
            end
            6'b000100, 6'b000101: begin
                push(c_decode(1'b0), rnd(), 1'b0);
                push(c_branch(op[0] ? ~z : z), rnd(), 1'b1);
            end
            6'b000010: begin
                push(c_decode(1'b0), rnd(), 1'b0);
                push(c_jump(), rnd(), 1'b1);
            end
            6'b001000: begin
                push(c_decode(1'b0), rnd(), 1'b0);
                push(c_addr(), rnd(), 1'b0);
                push(c_wb(1'b0, 1'b0), rnd(), 1'b1);
            end
            default: push(c_decode(1'b1), rnd(), 1'b0);
        endcase
    endfunction

    // Runs one instruction from FETCH; ncyc is cycles until the DUT is back in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int sf, input int sm, output int ncyc, output logic [31:0] dret);
        logic [31:0] start;
        build(op, fn, z, sf, sm);
        ncyc  = 0;
        start = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            opcode = op; funct = fn; zero = z;
            mem_ready = (i < e_q.size()) ? m_q[i] : 1'b0;
            @(negedge clk);
            if (i == 0) start = retired;
            check_int("retired", retired, ret_exp);
            check_int("retired_w4", {28'b0, w4_retired}, {28'b0, ret_exp[3:0]});
            if (i > sf && mem_read && !iord) begin
                check_ctl("next_fetch", got, c_fetch(1'b0));
                ncyc = i;
                break;
            end
            if (i < e_q.size()) begin
                check_ctl("ctl", got, e_q[i]);
                check_ctl("ctl_w4", got4, e_q[i]);
                if (r_q[i]) ret_exp++;
            end else begin
                check_ctl("overrun", got, c_fetch(1'b0));
            end
        end
        dret = retired - start;
    endtask

    task automatic step(input logic mr);
        @(posedge clk);
        #1;
        mem_ready = mr;
        @(negedge clk);
    endtask

    // Called mid low-phase: async reset, hold, release after an edge, one IDLE cycle.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_ctl("reset_ctl", got, '0);
        check_int("reset_retired", retired, 32'd0);
        check_int("reset_retired_w4", {28'b0, w4_retired}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_ctl("idle_after_release", got, '0);
        ret_exp = '0;
    endtask

    initial begin
        int          ncyc;
        logic [31:0] dret;
        logic [5:0]  op, fn;

        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000};
        legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        tbl[0]  = '{6'b000000, 6'b100010, 1'b0, 0, 0, 4, 1};
        tbl[1]  = '{6'b000000, 6'b100000, 1'b1, 1, 0, 5, 1};
        tbl[2]  = '{6'b000000, 6'b100100, 1'b0, 0, 0, 4, 1};
        tbl[3]  = '{6'b000000, 6'b100101, 1'b0, 0, 0, 4, 1};
        tbl[4]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1};
        tbl[5]  = '{6'b000000, 6'b000001, 1'b0, 0, 0, 3, 0};
        tbl[6]  = '{6'b100011, 6'b000000, 1'b0, 0, 3, 8, 1};
        tbl[7]  = '{6'b100011, 6'b111111, 1'b0, 0, 0, 5, 1};
        tbl[8]  = '{6'b101011, 6'b000000, 1'b0, 0, 2, 6, 1};
        tbl[9]  = '{6'b101011, 6'b000000, 1'b1, 2, 0, 6, 1};
        tbl[10] = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 1};
        tbl[11] = '{6'b000100, 6'b000000, 1'b0, 0, 0, 3, 1};
        tbl[12] = '{6'b000101, 6'b000000, 1'b1, 0, 0, 3, 1};
        tbl[13] = '{6'b000101, 6'b000000, 1'b0, 0, 0, 3, 1};
        tbl[14] = '{6'b000010, 6'b000000, 1'b0, 0, 0, 3, 1};
        tbl[15] = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1};
        tbl[16] = '{6'b111111, 6'b100000, 1'b0, 0, 0, 2, 0};
        tbl[17] = '{6'b100000, 6'b100000, 1'b0, 1, 0, 3, 0};

        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1; ret_exp = '0;
        @(negedge clk);
        do_reset();

        for (int t = 0; t < 18; t++) begin
            run_instr(tbl[t].op, tbl[t].fn, tbl[t].z, tbl[t].sf, tbl[t].sm, ncyc, dret);
            check_int($sformatf("cycles[%0d]", t), ncyc, tbl[t].cyc);
            check_int($sformatf("retire_delta[%0d]", t), dret, tbl[t].ret);
        end

        // Narrow counter wraps after 16 jumps.
        do_reset();
        for (int k = 0; k < 16; k++) run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, ncyc, dret);
        check_int("wrap_w4", {28'b0, w4_retired}, 32'd0);
        check_int("wrap_w32", retired, 32'd16);

        // Reset arriving while a store waits on memory.
        opcode = 6'b101011; funct = '0; zero = 1'b0;
        step(1'b1);
        check_ctl("sw_fetch", got, c_fetch(1'b1));
        step(1'b0);
        step(1'b0);
        check_ctl("sw_memadr", got, c_addr());
        step(1'b0);
        check_ctl("sw_memwrite", got, c_mem(1'b1));
        check_int("sw_retired_before", retired, 32'd16);
        do_reset();
        step(1'b0);
        check_ctl("fetch_after_reset", got, c_fetch(1'b0));

        for (int k = 0; k < 60; k++) begin
            int pick;
            pick = int'($urandom_range(0, 8));
            if (pick < 7)       op = legal_ops[pick];
            else if (pick == 7) op = 6'($urandom_range(0, 63));
            else                op = 6'b000000;
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : legal_fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), ncyc, dret);
            check_int("rand_cycles", ncyc, e_q.size());
            check_int("rand_retire_delta", dret, exp_ret);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  as the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  as the reset; asynchronous, active-low.
REQ-004 SHALL have port opcode  input  6  carrying instruction bits [31:26] from the IR.
REQ-005 SHALL have port funct  input  6  carrying instruction bits [5:0] from the IR.
REQ-006 SHALL have port zero  input  1  as the zero flag from the ALU.
REQ-007 SHALL have port mem_ready  input  1  as the memory-access-complete handshake.
REQ-008 SHALL have port alu_src_a  output  1  selecting the ALU A operand: 0=PC, 1=reg A.
REQ-009 SHALL have port alu_src_b  output  2  selecting the ALU B operand: 00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 SHALL have port alu_control  output  4  with encoding 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-011 SHALL have ports pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write  output  1  as datapath strobes/selects.
REQ-012 SHALL have port pc_source  output  2  selecting the next PC: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 SHALL have port illegal  output  1  as a one-cycle pulse on an unsupported opcode or funct.
REQ-014 SHALL have port retired  output  CNT_WIDTH  holding the count of completed instructions.

Function
REQ-015 SHALL implement the states IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, RWB, BRANCH, JUMP, ADDI_EX and ADDI_WB.
REQ-016 SHALL transition IDLE->FETCH unconditionally, and assert all outputs at 0 in IDLE.
REQ-017 SHALL, in FETCH, drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD and pc_source=00; pc_write and ir_write SHALL equal mem_ready; the FSM SHALL hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-018 SHALL, in DECODE, drive alu_src_a=0, alu_src_b=11 and ADD, and dispatch on opcode: 000000->EXEC, 100011/101011->MEMADR, 000100/000101->BRANCH, 000010->JUMP, 001000->ADDI_EX; any other opcode SHALL pulse illegal and go to FETCH.
REQ-019 SHALL, in MEMADR, drive alu_src_a=1, alu_src_b=10 and ADD; the next state SHALL be MEMREAD for lw and MEMWRITE for sw.
REQ-020 SHALL, in MEMREAD, drive mem_read=1 and iord=1, holding until mem_ready=1 and then going to MEMWB.
REQ-021 SHALL, in MEMWRITE, drive mem_write=1 and iord=1, holding until mem_ready=1 and then going to FETCH.
REQ-022 SHALL, in MEMWB, drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-023 SHALL, in EXEC, drive alu_src_a=1 and alu_src_b=00, with alu_control decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-024 SHALL, on any other funct in EXEC, drive alu_control=0010, pulse illegal and go to FETCH with no write-back; otherwise the FSM SHALL go to RWB.
REQ-025 SHALL, in RWB, drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-026 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=00, SUB and pc_source=01, then go to FETCH.
REQ-027 SHALL, in BRANCH, drive pc_write combinationally as (opcode==000100 & zero) | (opcode==000101 & ~zero).
REQ-028 SHALL, in JUMP, drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-029 SHALL, in ADDI_EX, drive alu_src_a=1, alu_src_b=10 and ADD, then go to ADDI_WB.
REQ-030 SHALL, in ADDI_WB, drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-031 SHALL drive every output not listed for a state at 0 in that state.
REQ-032 SHALL increment retired by 1 on the final cycle of each legal instruction (MEMWB, MEMWRITE with mem_ready=1, RWB, BRANCH, JUMP, ADDI_WB), wrapping modulo 2^CNT_WIDTH.
REQ-033 SHALL complete each instruction in the following cycle counts, with mem_ready=1, counted from FETCH entry to the next FETCH: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4; each mem_ready=0 cycle SHALL add 1 cycle.

Reset
REQ-034 SHALL, on rst_n=0 at any time including mid-instruction, immediately force the state to IDLE, retired to 0, and all outputs to 0.
REQ-035 SHALL, after rst_n deasserts, be in IDLE on the first rising edge and enter FETCH on the next.

Structure
REQ-036 SHALL define the state enum, opcode/funct constants, alu_control encodings and alu_src_b/pc_source encodings in a shared package, ctrl_pkg.
REQ-037 SHALL implement the funct->alu_control decode as a sub-module, alu_decoder, with a valid output.

Verification
REQ-038 SHALL verify: reset release then opcode=000000, funct=100010, mem_ready=1 -> states FETCH,DECODE,EXEC(alu_control=0110),RWB(reg_write=1,reg_dst=1) and retired=1.
REQ-039 SHALL verify: lw (100011) with mem_ready held at 0 for 3 cycles in MEMREAD -> 8 cycles total, mem_read=1 and iord=1 throughout MEMREAD, and MEMWB with mem_to_reg=1.
REQ-040 SHALL verify: beq with zero=1 -> pc_write=1 and pc_source=01 in BRANCH; bne with zero=1 -> pc_write=0; retired increments by 1 in both cases.
REQ-041 SHALL verify: opcode=111111 -> illegal=1 for one cycle in DECODE, then FETCH, with retired unchanged.
REQ-042 SHALL verify: rst_n=0 asserted mid-MEMWRITE -> mem_write=0 immediately, retired=0, and state IDLE.
REQ-043 SHALL verify: CNT_WIDTH=4 with 16 j instructions -> retired wraps from 15 to 0.
